// File: rtl/si_tag_encoder.sv
// si_tag_encoder: serialises (time, channel) tags into 32-bit tag words packed into AXI-Stream beats
module si_tag_encoder #(
    parameter int CHANNEL_COUNT   = 20,
    parameter int DATA_WIDTH_OUT  = 128,
    parameter int KEEP_WIDTH_OUT  = DATA_WIDTH_OUT / 8,
    parameter int NUMBER_OF_WORDS = DATA_WIDTH_OUT / 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [63:0]               s_axis_tagtime,
    input  logic signed [5:0]         s_axis_channel,
    input  logic                      s_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH_OUT-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH_OUT-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [31:0]               m_axis_tuser,
    output logic [15:0]               drop_count
);
    localparam int LW = $clog2(NUMBER_OF_WORDS) + 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, PACK, EMIT} state_t;

    state_t             state;
    logic [63:0]        quot;
    logic [11:0]        rem;
    logic [5:0]         count;
    logic signed [5:0]  tag_channel;
    logic               tag_last;
    logic               pending;
    logic [LW-1:0]      lane;
    logic [12:0]        trial;
    logic               ge;
    logic signed [7:0]  ch_x;
    logic               ch_ok;
    logic [5:0]         number;
    logic [31:0]        wrap;
    logic [31:0]        word;

    assign s_axis_tready = (state == IDLE);

    // Divider step, channel mapping and tag word assembly
    always_comb begin
        trial  = {rem, quot[63]};
        ge     = trial >= 13'd4000;
        ch_x   = 8'(tag_channel);
        ch_ok  = (ch_x != 8'sd0) && (ch_x <= CHANNEL_COUNT) && (ch_x >= -CHANNEL_COUNT);
        number = 6'(ch_x > 8'sd0 ? ch_x - 8'sd1 : 8'(CHANNEL_COUNT) - 8'sd1 - ch_x);
        wrap   = quot[43:12];
        word   = {2'b01, number, rem, quot[11:0]};
    end

    // Accept, divide, pack into the open beat and emit it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            quot          <= '0;
            rem           <= '0;
            count         <= '0;
            tag_channel   <= '0;
            tag_last      <= 1'b0;
            pending       <= 1'b0;
            lane          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            drop_count    <= '0;
        end else begin
            case (state)
                IDLE: if (s_axis_tvalid) begin
                    quot        <= s_axis_tagtime;
                    rem         <= '0;
                    count       <= '0;
                    tag_channel <= s_axis_channel;
                    tag_last    <= s_axis_tlast;
                    state       <= DIVIDE;
                end
                DIVIDE: begin
                    quot  <= {quot[62:0], ge};
                    rem   <= ge ? 12'(trial - 13'd4000) : trial[11:0];
                    count <= count + 6'd1;
                    if (count == 6'd63) state <= PACK;
                end
                PACK: begin
                    pending <= 1'b0;
                    if (!ch_ok) begin
                        drop_count <= drop_count + {15'd0, drop_count != 16'hFFFF};
                        if (tag_last && lane != '0) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b1;
                            state         <= EMIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (lane != '0 && wrap != m_axis_tuser) begin
                        // A wrap change closes the open beat; this word is packed afterwards
                        m_axis_tvalid <= 1'b1;
                        pending       <= 1'b1;
                        state         <= EMIT;
                    end else begin
                        m_axis_tdata[32*lane +: 32] <= word;
                        m_axis_tkeep[4*lane +: 4]   <= 4'hF;
                        m_axis_tuser                <= wrap;
                        lane                        <= lane + 1'b1;
                        if (tag_last || lane == LW'(NUMBER_OF_WORDS - 1)) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= tag_last;
                            state         <= EMIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                EMIT: if (m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tdata  <= '0;
                    m_axis_tkeep  <= '0;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tuser  <= '0;
                    lane          <= '0;
                    state         <= pending ? PACK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_si_tag_encoder.sv
// tb_si_tag_encoder: scoreboard bench for si_tag_encoder with directed tags
module tb_si_tag_encoder;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tready;
    logic [63:0]        s_axis_tagtime = '0;
    logic signed [5:0]  s_axis_channel = '0;
    logic               s_axis_tlast = 1'b0;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b1;
    logic [127:0]       m_axis_tdata;
    logic [15:0]        m_axis_tkeep;
    logic               m_axis_tlast;
    logic [31:0]        m_axis_tuser;
    logic [15:0]        drop_count;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
        logic [31:0]  u;
    } beat_t;

    beat_t sbq[$];
    int compared = 0;
    int mismatched = 0;

    localparam logic [63:0] T1  = 64'd49172017;
    localparam logic [63:0] W7  = 64'd114688000;
    localparam logic [63:0] W8  = 64'd131072000;
    localparam logic [63:0] TRT = 64'd123456789012;

    always #5 clk = ~clk;

    si_tag_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tagtime(s_axis_tagtime), .s_axis_channel(s_axis_channel),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .drop_count(drop_count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [127:0] d, input logic [15:0] k, input logic l, input logic [31:0] u);
        beat_t b;
        b.d = d; b.k = k; b.l = l; b.u = u;
        sbq.push_back(b);
    endtask

    task automatic send(input logic [63:0] t, input logic signed [5:0] c, input logic l);
        int n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) chk("send_ready_timeout", 0, 1);
        s_axis_tvalid = 1'b1; s_axis_tagtime = t; s_axis_channel = c; s_axis_tlast = l;
        @(posedge clk);
        @(negedge clk);
        s_axis_tvalid = 1'b0; s_axis_tagtime = ~t; s_axis_channel = ~c; s_axis_tlast = ~l;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(s_axis_tready && !m_axis_tvalid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!m_axis_tvalid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!m_axis_tvalid) chk("out_timeout", 0, 1);
    endtask

    // Scoreboard monitor: every accepted beat is checked against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", m_axis_tdata, 0);
            end else begin
                beat_t b;
                b = sbq.pop_front();
                chk("beat_tdata", m_axis_tdata, b.d);
                chk("beat_tkeep", 128'(m_axis_tkeep), 128'(b.k));
                chk("beat_tlast", 128'(m_axis_tlast), 128'(b.l));
                chk("beat_tuser", 128'(m_axis_tuser), 128'(b.u));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [31:0] lw;
        logic [63:0] rt;
        int rc;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 128'(m_axis_tvalid), 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tkeep", 128'(m_axis_tkeep), 0);
        chk("rst_tlast", 128'(m_axis_tlast), 0);
        chk("rst_tuser", 128'(m_axis_tuser), 0);
        chk("rst_drop", 128'(drop_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sready", 128'(s_axis_tready), 1);

        expect_beat(128'h42011005, 16'h000F, 1'b1, 32'd3);
        send(T1, 6'sd3, 1'b1);
        chk("sready_drop", 128'(s_axis_tready), 0);
        wait_out(cyc);
        chk("t1_latency", 128'(cyc), 66);
        wait_idle();

        expect_beat(128'h54000000, 16'h000F, 1'b1, 32'd0);
        send(64'd0, -6'sd1, 1'b1);
        wait_idle();

        expect_beat({32'h40004004, 32'h40003003, 32'h40002002, 32'h40001001}, 16'hFFFF, 1'b0, 32'd7);
        for (int i = 1; i <= 4; i++) send(W7 + 64'(4001 * i), 6'sd1, 1'b0);
        wait_idle();

        expect_beat({64'd0, 32'h40002002, 32'h40001001}, 16'h00FF, 1'b0, 32'd7);
        expect_beat(128'h40000000, 16'h000F, 1'b1, 32'd8);
        send(W7 + 64'd4001, 6'sd1, 1'b0);
        send(W7 + 64'd8002, 6'sd1, 1'b0);
        send(W8, 6'sd1, 1'b1);
        wait_idle();

        send(64'd100, 6'sd0, 1'b0);
        send(64'd100, 6'sd21, 1'b0);
        wait_idle();
        chk("drop_two", 128'(drop_count), 2);

        expect_beat(128'h40001001, 16'h000F, 1'b1, 32'd7);
        send(W7 + 64'd4001, 6'sd1, 1'b0);
        send(64'd5, -6'sd25, 1'b1);
        wait_idle();
        chk("drop_flush", 128'(drop_count), 3);

        m_axis_tready = 1'b0;
        expect_beat(128'h42011005, 16'h000F, 1'b1, 32'd3);
        send(T1, 6'sd3, 1'b1);
        wait_out(cyc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_tvalid", 128'(m_axis_tvalid), 1);
            chk("hold_tdata", m_axis_tdata, 128'h42011005);
            chk("hold_tuser", 128'(m_axis_tuser), 3);
            chk("hold_sready", 128'(s_axis_tready), 0);
        end
        m_axis_tready = 1'b1;
        wait_idle();

        send(T1, 6'sd3, 1'b1);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 128'(m_axis_tvalid), 0);
        chk("mid_rst_tdata", m_axis_tdata, 0);
        chk("mid_rst_drop", 128'(drop_count), 0);
        chk("mid_rst_sready", 128'(s_axis_tready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_quiet", 128'(m_axis_tvalid), 0);

        expect_beat(128'h583F4345, 16'h000F, 1'b1, 32'd7535);
        send(TRT, -6'sd5, 1'b1);
        wait_out(cyc);
        lw = m_axis_tdata[31:0];
        rt = (64'(m_axis_tuser) * 64'd4096 + 64'(lw[11:0])) * 64'd4000 + 64'(lw[23:12]);
        rc = (lw[29:24] < 6'd20) ? int'(lw[29:24]) + 1 : 19 - int'(lw[29:24]);
        chk("roundtrip_time", 128'(rt), 128'(TRT));
        chk("roundtrip_channel", 128'(rc), 128'(-5));
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queue_empty", 128'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
